pll_rst_seq: RTL and testbench

- Power-up and relock sequencer that sits directly downstream of the PLL wrapper.
- Drives the PLL reset, watches the PLL lock, and gates the two PLL output clocks in order (enclk0, then enclk2).
- Releases the system reset only after lock has been stable for a set time.
- Runs on the free-running board reference clock (the same clock as PLL calibration, 50 MHz) so it keeps working while the PLL is unlocked.

---
 rtl/pll_rst_seq_pkg.sv | 31 +++
 rtl/pll_rst_seq_sync_2ff.sv | 29 ++
 rtl/pll_rst_seq.sv | 204 ++++++++++++++++++++
 tb/tb_pll_rst_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_seq_pkg.sv
// Shared definitions for the PLL reset/relock sequencer: state encoding,
// default timing constants and the relock counter width.
package pll_rst_seq_pkg;

    // Sequencer states. Encodings 6 and 7 are unused and recover to RESET_PLL.
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        EN_CLK    = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } pll_seq_state_e;

    // Default timing, in reference clock cycles (50 MHz board clock).
    localparam int DEF_RST_CYCLES         = 16;
    localparam int DEF_LOCK_TIMEOUT       = 65536;
    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_ENABLE_GAP         = 8;
    localparam int DEF_RELEASE_DELAY      = 16;
    localparam int DEF_MAX_RETRIES        = 4;

    // Width of the saturating lock-loss counter.
    localparam int RELOCK_CNT_W = 8;

    // Larger of two integers, used to size the shared down-counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_rst_seq_sync_2ff.sv
// Generic single-bit two-flop synchroniser with asynchronous active-low
// reset; output resets to 0. Reused for other clock-domain-crossing bits.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old
            // values at the same edge; blocking here would collapse the chain
            // into a single flop.
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL power-up and relock sequencer. Runs on the free-running reference
// clock, pulses the PLL reset, waits for a stable lock, enables the two PLL
// output clocks in order and finally releases the system reset.
module pll_rst_seq
    import pll_rst_seq_pkg::*;
#(
    parameter int RST_CYCLES         = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int ENABLE_GAP         = DEF_ENABLE_GAP,
    parameter int RELEASE_DELAY      = DEF_RELEASE_DELAY,
    parameter int MAX_RETRIES        = DEF_MAX_RETRIES
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    pll_lock_i,
    input  logic                    relock_req_i,
    output logic                    pll_reset_o,
    output logic                    enclk0_o,
    output logic                    enclk2_o,
    output logic                    sys_rst_no,
    output logic                    ready_o,
    output logic                    fail_o,
    output logic [RELOCK_CNT_W-1:0] relock_count_o
);

    // One counter serves every timed state, so it is sized for the longest.
    localparam int MAX_DUR = max_int(max_int(max_int(RST_CYCLES, LOCK_TIMEOUT),
                                             max_int(LOCK_STABLE_CYCLES, ENABLE_GAP)),
                                     RELEASE_DELAY);
    localparam int CNT_W   = $clog2(MAX_DUR + 1);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    // Reload values: a state lasting N cycles loads N-1 and expires at 0.
    localparam logic [CNT_W-1:0] RST_RELOAD     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_RELOAD = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_RELOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_RELOAD     = CNT_W'(ENABLE_GAP - 1);
    localparam logic [CNT_W-1:0] RELEASE_RELOAD = CNT_W'(RELEASE_DELAY - 1);

    pll_seq_state_e          state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    gap_done_q, gap_done_d;
    logic [RETRY_W-1:0]      retry_q, retry_d, retry_inc;
    logic [RELOCK_CNT_W-1:0] relock_cnt_q, relock_cnt_d;
    logic                    expired;
    logic                    lock_s;

    logic pll_reset_q, pll_reset_d;
    logic enclk0_q, enclk0_d;
    logic enclk2_q, enclk2_d;
    logic sys_rst_nq, sys_rst_nd;
    logic ready_q, ready_d;
    logic fail_q, fail_d;

    // PLL lock is asynchronous to the reference clock; every decision uses lock_s.
    sync_2ff u_lock_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pll_lock_i),
        .q_o    (lock_s)
    );

    // Next-state, counter, retry, relock-count and registered-output decode.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        cnt_d        = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
        gap_done_d   = gap_done_q;
        retry_d      = retry_q;
        relock_cnt_d = relock_cnt_q;
        expired      = (cnt_q == '0);
        retry_inc    = retry_q + RETRY_W'(1);

        if (relock_req_i) begin
            // A restart request beats lock loss and expiry in the same cycle.
            state_d    = RESET_PLL;
            cnt_d      = RST_RELOAD;
            gap_done_d = 1'b0;
            retry_d    = '0;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (expired) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = TIMEOUT_RELOAD;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                        cnt_d   = STABLE_RELOAD;
                    end else if (expired) begin
                        retry_d = retry_inc;
                        if (retry_inc == RETRY_W'(MAX_RETRIES)) begin
                            state_d = FAIL;
                            cnt_d   = '0;
                        end else begin
                            state_d = RESET_PLL;
                            cnt_d   = RST_RELOAD;
                        end
                    end
                end
                STABLE: begin
                    // A glitch restarts the lock wait without consuming a retry.
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = TIMEOUT_RELOAD;
                    end else if (expired) begin
                        state_d    = EN_CLK;
                        cnt_d      = GAP_RELOAD;
                        gap_done_d = 1'b0;
                        retry_d    = '0;
                    end
                end
                EN_CLK: begin
                    if (!lock_s) begin
                        state_d    = RESET_PLL;
                        cnt_d      = RST_RELOAD;
                        gap_done_d = 1'b0;
                        if (relock_cnt_q != '1) relock_cnt_d = relock_cnt_q + RELOCK_CNT_W'(1);
                    end else if (expired) begin
                        if (!gap_done_q) begin
                            gap_done_d = 1'b1;
                            cnt_d      = RELEASE_RELOAD;
                        end else begin
                            state_d    = RUN;
                            gap_done_d = 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d = RESET_PLL;
                        cnt_d   = RST_RELOAD;
                        if (relock_cnt_q != '1) relock_cnt_d = relock_cnt_q + RELOCK_CNT_W'(1);
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d    = RESET_PLL;
                    cnt_d      = RST_RELOAD;
                    gap_done_d = 1'b0;
                end
            endcase
        end

        // Outputs are decoded from the next state and then registered.
        pll_reset_d = (state_d == RESET_PLL) || (state_d == FAIL);
        enclk0_d    = (state_d == EN_CLK) || (state_d == RUN);
        enclk2_d    = ((state_d == EN_CLK) && gap_done_d) || (state_d == RUN);
        sys_rst_nd  = (state_d == RUN);
        ready_d     = (state_d == RUN);
        fail_d      = (state_d == FAIL);
    end

    // Sequencer state, shared counter, retry and relock counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= RESET_PLL;
            cnt_q        <= RST_RELOAD;
            gap_done_q   <= 1'b0;
            retry_q      <= '0;
            relock_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gap_done_q   <= gap_done_d;
            retry_q      <= retry_d;
            relock_cnt_q <= relock_cnt_d;
        end
    end

    // Output registers; reset values hold the PLL in reset and the system down.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pll_reset_q <= 1'b1;
            enclk0_q    <= 1'b0;
            enclk2_q    <= 1'b0;
            sys_rst_nq  <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            pll_reset_q <= pll_reset_d;
            enclk0_q    <= enclk0_d;
            enclk2_q    <= enclk2_d;
            sys_rst_nq  <= sys_rst_nd;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_reset_o    = pll_reset_q;
    assign enclk0_o       = enclk0_q;
    assign enclk2_o       = enclk2_q;
    assign sys_rst_no     = sys_rst_nq;
    assign ready_o        = ready_q;
    assign fail_o         = fail_q;
    assign relock_count_o = relock_cnt_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed testbench for pll_rst_seq with shortened timing parameters.
module tb_pll_rst_seq;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       pll_lock_i;
    logic       relock_req_i;
    logic       pll_reset_o;
    logic       enclk0_o;
    logic       enclk2_o;
    logic       sys_rst_no;
    logic       ready_o;
    logic       fail_o;
    logic [7:0] relock_count_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef enum int {S_PLLRST, S_EN0, S_EN2, S_SYSRST, S_READY, S_FAIL} sig_e;

    pll_rst_seq #(
        .RST_CYCLES         (4),
        .LOCK_TIMEOUT       (32),
        .LOCK_STABLE_CYCLES (8),
        .ENABLE_GAP         (2),
        .RELEASE_DELAY      (3),
        .MAX_RETRIES        (2)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .pll_lock_i     (pll_lock_i),
        .relock_req_i   (relock_req_i),
        .pll_reset_o    (pll_reset_o),
        .enclk0_o       (enclk0_o),
        .enclk2_o       (enclk2_o),
        .sys_rst_no     (sys_rst_no),
        .ready_o        (ready_o),
        .fail_o         (fail_o),
        .relock_count_o (relock_count_o)
    );

    always #10 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic get_sig(input sig_e sel);
        case (sel)
            S_PLLRST: return pll_reset_o;
            S_EN0:    return enclk0_o;
            S_EN2:    return enclk2_o;
            S_SYSRST: return sys_rst_no;
            S_READY:  return ready_o;
            default:  return fail_o;
        endcase
    endfunction

    // Tick until the selected output reaches val; n is the number of edges taken.
    task automatic wait_level(input sig_e sel, input logic val, input int budget,
                              output int n, output logic saw_rst);
        n = 0;
        saw_rst = 1'b0;
        while (get_sig(sel) !== val && n < budget) begin
            tick();
            n++;
            saw_rst |= pll_reset_o;
        end
    endtask

    task automatic check_reset_outputs(input string tag, input logic [7:0] exp_cnt);
        check({tag, "_pll_reset"}, pll_reset_o, 1);
        check({tag, "_enclk0"},    enclk0_o,    0);
        check({tag, "_enclk2"},    enclk2_o,    0);
        check({tag, "_sys_rst_n"}, sys_rst_no,  0);
        check({tag, "_ready"},     ready_o,     0);
        check({tag, "_fail"},      fail_o,      0);
        check({tag, "_relock_cnt"}, relock_count_o, exp_cnt);
    endtask

    // System reset released implies both clocks enabled and the PLL out of reset.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && sys_rst_no === 1'b1)
            check("invariant", {enclk0_o, enclk2_o, pll_reset_o}, 3'b110);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic seen;
        int   exp_cnt;

        rst_ni       = 1'b0;
        pll_lock_i   = 1'b0;
        relock_req_i = 1'b0;
        repeat (3) tick();
        check_reset_outputs("por", 8'd0);

        // ---------------- Happy path ----------------
        @(negedge clk_i);
        rst_ni = 1'b1;
        wait_level(S_PLLRST, 1'b0, 100, n, seen);
        check("hp_rst_pulse_len", n, 4);
        repeat (5) tick();
        pll_lock_i = 1'b1;
        // 2 sync edges + 1 edge into STABLE + 8 stable cycles = 11 edges.
        wait_level(S_EN0, 1'b1, 100, n, seen);
        check("hp_enclk0_delay", n, 11);
        check("hp_enclk2_low", enclk2_o, 0);
        check("hp_sys_rst_low", sys_rst_no, 0);
        wait_level(S_EN2, 1'b1, 100, n, seen);
        check("hp_enclk2_gap", n, 2);
        wait_level(S_SYSRST, 1'b1, 100, n, seen);
        check("hp_release_delay", n, 3);
        check("hp_ready", ready_o, 1);
        check("hp_relock_cnt", relock_count_o, 0);
        check("hp_fail", fail_o, 0);

        // ---------------- Lock glitch in STABLE ----------------
        relock_req_i = 1'b1;
        tick();
        relock_req_i = 1'b0;
        check_reset_outputs("req", 8'd0);
        wait_level(S_PLLRST, 1'b0, 100, n, seen);
        check("gl_rst_pulse_len", n, 4);
        // Lock is still high: STABLE is entered on the next edge.
        repeat (5) tick();
        pll_lock_i = 1'b0;
        tick();
        pll_lock_i = 1'b1;
        // Low seen at edge 2, WAIT_LOCK at edge 2, STABLE at 3, 8 cycles more.
        wait_level(S_EN0, 1'b1, 100, n, seen);
        check("gl_enclk0_delay", n, 11);
        check("gl_no_second_reset", seen, 0);
        wait_level(S_EN2, 1'b1, 100, n, seen);
        check("gl_enclk2_gap", n, 2);
        wait_level(S_SYSRST, 1'b1, 100, n, seen);
        check("gl_release_delay", n, 3);

        // ---------------- Lock loss in RUN ----------------
        pll_lock_i = 1'b0;
        wait_level(S_SYSRST, 1'b0, 100, n, seen);
        check("ll_detect_latency", n, 3);
        check("ll_enclk0", enclk0_o, 0);
        check("ll_enclk2", enclk2_o, 0);
        check("ll_ready", ready_o, 0);
        check("ll_pll_reset", pll_reset_o, 1);
        check("ll_relock_cnt", relock_count_o, 1);
        pll_lock_i = 1'b1;
        wait_level(S_PLLRST, 1'b0, 100, n, seen);
        check("ll_rst_pulse_len", n, 4);
        // Lock already synchronised: STABLE next edge, then 8 cycles.
        wait_level(S_EN0, 1'b1, 100, n, seen);
        check("ll_enclk0_delay", n, 9);
        wait_level(S_EN2, 1'b1, 100, n, seen);
        check("ll_enclk2_gap", n, 2);
        wait_level(S_SYSRST, 1'b1, 100, n, seen);
        check("ll_release_delay", n, 3);

        // ---------------- relock_req together with lock loss ----------------
        pll_lock_i = 1'b0;
        tick();
        tick();
        check("sim_still_run", sys_rst_no, 1);
        relock_req_i = 1'b1;
        tick();
        relock_req_i = 1'b0;
        check("sim_pll_reset", pll_reset_o, 1);
        check("sim_sys_rst_n", sys_rst_no, 0);
        check("sim_relock_cnt", relock_count_o, 1);
        pll_lock_i = 1'b1;
        wait_level(S_READY, 1'b1, 200, n, seen);
        check("sim_back_to_run", ready_o, 1);

        // ---------------- Repeated lock loss, saturation ----------------
        for (int i = 2; i <= 300; i++) begin
            pll_lock_i = 1'b0;
            wait_level(S_SYSRST, 1'b0, 50, n, seen);
            pll_lock_i = 1'b1;
            wait_level(S_READY, 1'b1, 100, n, seen);
            exp_cnt = (i > 255) ? 255 : i;
            check("sat_relock_cnt", relock_count_o, exp_cnt);
        end

        // ---------------- Timeout and FAIL ----------------
        pll_lock_i   = 1'b0;
        relock_req_i = 1'b1;
        tick();
        relock_req_i = 1'b0;
        wait_level(S_PLLRST, 1'b0, 100, n, seen);
        check("to_rst1_len", n, 4);
        wait_level(S_PLLRST, 1'b1, 100, n, seen);
        check("to_wait1_len", n, 32);
        check("to_no_fail_yet", fail_o, 0);
        wait_level(S_PLLRST, 1'b0, 100, n, seen);
        check("to_rst2_len", n, 4);
        wait_level(S_PLLRST, 1'b1, 100, n, seen);
        check("to_wait2_len", n, 32);
        check("to_fail", fail_o, 1);
        repeat (10) tick();
        check("to_fail_held", fail_o, 1);
        check("to_pll_reset_held", pll_reset_o, 1);
        check("to_enclk0", enclk0_o, 0);
        check("to_sys_rst_n", sys_rst_no, 0);
        check("to_relock_cnt", relock_count_o, 255);
        relock_req_i = 1'b1;
        tick();
        relock_req_i = 1'b0;
        check("to_req_fail_clr", fail_o, 0);
        check("to_req_pll_reset", pll_reset_o, 1);
        wait_level(S_PLLRST, 1'b0, 100, n, seen);
        check("to_restart_len", n, 4);

        // ---------------- Async reset mid-EN_CLK ----------------
        pll_lock_i = 1'b1;
        wait_level(S_EN0, 1'b1, 100, n, seen);
        check("ar_in_en_clk", enclk0_o, 1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("ar", 8'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        wait_level(S_PLLRST, 1'b0, 100, n, seen);
        check("ar_rst_pulse_len", n, 4);
        wait_level(S_READY, 1'b1, 100, n, seen);
        check("ar_back_to_run", ready_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
